// File: rtl/timer_pkg.sv
// Shared definitions for the multi-channel timer: mode encodings and default widths.
package timer_pkg;

    localparam int DEF_N_CH  = 4;
    localparam int DEF_CNT_W = 16;
    localparam int DEF_IRQ_W = 8;

    typedef enum logic [1:0] {
        MODO_OFF       = 2'b00,
        MODO_ONESHOT   = 2'b01,
        MODO_PERIODICO = 2'b10,
        MODO_RESERVADO = 2'b11
    } modo_t;

    // Index width for n items, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/timer_multicanal_if.sv
// Configuration and interrupt bus between the cpu (master) and the timer block (slave).
interface timer_multicanal_if #(
    parameter int N_CH  = timer_pkg::DEF_N_CH,
    parameter int CNT_W = timer_pkg::DEF_CNT_W,
    parameter int IRQ_W = timer_pkg::DEF_IRQ_W
);
    import timer_pkg::*;

    localparam int CH_W = idx_w(N_CH);
    localparam int ID_W = idx_w(IRQ_W);

    logic             cfg_we;
    logic [CH_W-1:0]  cfg_ch;
    logic [1:0]       cfg_modo;
    logic [CNT_W-1:0] cfg_periodo;
    logic [IRQ_W-1:0] ack;
    logic [IRQ_W-1:0] interrupcion;
    logic             irq_valid;
    logic [ID_W-1:0]  irq_id;

    modport master (
        output cfg_we, cfg_ch, cfg_modo, cfg_periodo, ack,
        input  interrupcion, irq_valid, irq_id
    );

    modport slave (
        input  cfg_we, cfg_ch, cfg_modo, cfg_periodo, ack,
        output interrupcion, irq_valid, irq_id
    );

endinterface

// File: rtl/timer_canal.sv
// One timer channel: mode/period registers, free-running counter and a sticky pending flag.
module timer_canal
    import timer_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [1:0]       modo_cfg,
    input  logic [CNT_W-1:0] periodo_cfg,
    input  logic             ack,
    output logic             pending
);

    modo_t            modo;
    logic [CNT_W-1:0] periodo;
    logic [CNT_W-1:0] cnt;
    logic             pend;
    logic             enabled;
    logic             evento;

    assign enabled = ((modo == MODO_ONESHOT) || (modo == MODO_PERIODICO)) && (periodo != '0);
    // A write restarts the count, so it can never coincide with an event.
    assign evento  = enabled && !we && (cnt == (periodo - CNT_W'(1)));

    always_ff @(posedge clk) begin
        if (reset) begin
            modo    <= MODO_OFF;
            periodo <= '0;
            cnt     <= '0;
            pend    <= 1'b0;
        end else begin
            pend <= (pend & ~ack) | evento;
            if (we) begin
                modo    <= modo_t'(modo_cfg);
                periodo <= periodo_cfg;
                cnt     <= '0;
            end else if (evento) begin
                cnt <= '0;
                if (modo == MODO_ONESHOT) begin
                    modo <= MODO_OFF;
                end
            end else if (enabled) begin
                cnt <= cnt + CNT_W'(1);
            end else begin
                cnt <= '0;
            end
        end
    end

    assign pending = pend;

endmodule

// File: rtl/timer_multicanal.sv
// Multi-channel timer: N_CH independent channels feeding a level interrupt vector and a priority encoder.
module timer_multicanal
    import timer_pkg::*;
#(
    parameter int N_CH  = DEF_N_CH,
    parameter int CNT_W = DEF_CNT_W,
    parameter int IRQ_W = DEF_IRQ_W
) (
    input  logic                clk,
    input  logic                reset,
    timer_multicanal_if.slave   bus
);

    localparam int CH_W = idx_w(N_CH);
    localparam int ID_W = idx_w(IRQ_W);

    logic [N_CH-1:0]  pend;
    logic [IRQ_W-1:0] irq_vec;
    logic [ID_W-1:0]  id;

    // Out-of-range channel numbers match no instance, so such writes vanish.
    for (genvar i = 0; i < N_CH; i++) begin : g_canal
        timer_canal #(
            .CNT_W(CNT_W)
        ) u_canal (
            .clk        (clk),
            .reset      (reset),
            .we         (bus.cfg_we && (bus.cfg_ch == CH_W'(i))),
            .modo_cfg   (bus.cfg_modo),
            .periodo_cfg(bus.cfg_periodo),
            .ack        (bus.ack[i]),
            .pending    (pend[i])
        );
    end

    if (IRQ_W > N_CH) begin : g_pad
        logic unused_ack;
        assign irq_vec    = {{(IRQ_W-N_CH){1'b0}}, pend};
        assign unused_ack = ^bus.ack[IRQ_W-1:N_CH];
    end else begin : g_nopad
        assign irq_vec = pend;
    end

    // Scan from the top so the lowest pending line wins.
    always_comb begin
        id = '0;
        for (int i = IRQ_W - 1; i >= 0; i--) begin
            if (irq_vec[i]) begin
                id = ID_W'(i);
            end
        end
    end

    assign bus.interrupcion = irq_vec;
    assign bus.irq_valid    = |irq_vec;
    assign bus.irq_id       = id;

endmodule
